// File: rtl/ofm_packer_pkg.sv
// Shared widths and bank-state encoding for the IFM parser / OFM packer pair.
package ofm_packer_pkg;
  localparam int INPUT_WIDTH  = 512;
  localparam int OUTPUT_WIDTH = 80;
  localparam int REG_NUM      = 5;
  localparam int COMMON_DEN   = INPUT_WIDTH * REG_NUM;
  localparam int MAX_CNT      = COMMON_DEN / OUTPUT_WIDTH;
  localparam int SLICE_W      = 5;
  localparam int WORD_W       = 3;

  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(MAX_CNT - 1);
  localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(REG_NUM - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;
endpackage

// File: rtl/ofm_pack_bank.sv
// One group buffer: slice-granular writes, word-granular reads.
module ofm_pack_bank
  import ofm_packer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    wr_en_i,
  input  logic [SLICE_W-1:0]      slice_idx_i,
  input  logic [OUTPUT_WIDTH-1:0] wr_data_i,
  input  logic [WORD_W-1:0]       word_idx_i,
  output logic [INPUT_WIDTH-1:0]  word_o
);

  logic [COMMON_DEN-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (clr_i) begin
      data_q <= '0;
    end else if (wr_en_i) begin
      data_q[int'(slice_idx_i)*OUTPUT_WIDTH +: OUTPUT_WIDTH] <= wr_data_i;
    end
  end

  always_comb begin
    word_o = '0;
    if (int'(word_idx_i) < REG_NUM) begin
      word_o = data_q[int'(word_idx_i)*INPUT_WIDTH +: INPUT_WIDTH];
    end
  end

endmodule

// File: rtl/ofm_packer.sv
// Packs PE result slices into stream words through two ping-pong banks.
module ofm_packer
  import ofm_packer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_conv_pulse,
  input  logic [OUTPUT_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [INPUT_WIDTH-1:0]  out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy
);

  bank_state_e state_q [2];
  bank_state_e state_d [2];
  logic [1:0] last_q, last_d;
  logic fill_ptr_q, fill_ptr_d;
  logic drain_ptr_q, drain_ptr_d;
  logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
  logic [WORD_W-1:0] word_cnt_q, word_cnt_d;
  logic out_valid_q, out_valid_d;
  logic out_last_q, out_last_d;
  logic [INPUT_WIDTH-1:0] out_data_q, out_data_d;

  logic [1:0] wr_en, clr;
  logic [INPUT_WIDTH-1:0] bank_word [2];
  logic [INPUT_WIDTH-1:0] rd_word;
  logic [WORD_W-1:0] rd_idx;
  logic rd_bank;
  logic accept, hs, done;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ofm_pack_bank u_bank (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr_i       (clr[b]),
      .wr_en_i     (wr_en[b]),
      .slice_idx_i (slice_cnt_q),
      .wr_data_i   (in_data),
      .word_idx_i  (rd_idx),
      .word_o      (bank_word[b])
    );
  end

  assign in_ready = (state_q[fill_ptr_q] != BANK_FULL);
  assign accept   = in_valid && in_ready;
  assign hs       = out_valid_q && out_ready;
  assign done     = hs && (word_cnt_q == LAST_WORD);
  assign rd_word  = bank_word[rd_bank];

  // Read address depends only on registered state and out_ready.
  always_comb begin
    rd_bank = drain_ptr_q;
    rd_idx  = '0;
    if (done) begin
      rd_bank = ~drain_ptr_q;
    end else if (hs) begin
      rd_idx = word_cnt_q + 3'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    fill_ptr_d  = fill_ptr_q;
    drain_ptr_d = drain_ptr_q;
    slice_cnt_d = slice_cnt_q;
    word_cnt_d  = word_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    wr_en       = '0;
    clr         = '0;
    if (start_conv_pulse) begin
      state_d[0]  = BANK_EMPTY;
      state_d[1]  = BANK_EMPTY;
      last_d      = '0;
      fill_ptr_d  = 1'b0;
      drain_ptr_d = 1'b0;
      slice_cnt_d = '0;
      word_cnt_d  = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_data_d  = '0;
      clr         = 2'b11;
    end else begin
      if (accept) begin
        wr_en[fill_ptr_q] = 1'b1;
        state_d[fill_ptr_q] = BANK_FILLING;
        slice_cnt_d = slice_cnt_q + 5'd1;
        if (slice_cnt_q == LAST_SLICE || in_last) begin
          state_d[fill_ptr_q] = BANK_FULL;
          last_d[fill_ptr_q]  = in_last;
          fill_ptr_d  = ~fill_ptr_q;
          slice_cnt_d = '0;
        end
      end
      if (done) begin
        state_d[drain_ptr_q] = BANK_EMPTY;
        last_d[drain_ptr_q]  = 1'b0;
        clr[drain_ptr_q]     = 1'b1;
        drain_ptr_d = ~drain_ptr_q;
        word_cnt_d  = '0;
        out_last_d  = 1'b0;
        out_valid_d = (state_q[~drain_ptr_q] == BANK_FULL);
        if (state_q[~drain_ptr_q] == BANK_FULL) begin
          out_data_d = rd_word;
        end
      end else if (hs) begin
        word_cnt_d = word_cnt_q + 3'd1;
        out_data_d = rd_word;
        out_last_d = (rd_idx == LAST_WORD) && last_q[drain_ptr_q];
      end else if (!out_valid_q && state_q[drain_ptr_q] == BANK_FULL) begin
        word_cnt_d  = '0;
        out_valid_d = 1'b1;
        out_last_d  = 1'b0;
        out_data_d  = rd_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0]  <= BANK_EMPTY;
      state_q[1]  <= BANK_EMPTY;
      last_q      <= '0;
      fill_ptr_q  <= 1'b0;
      drain_ptr_q <= 1'b0;
      slice_cnt_q <= '0;
      word_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      fill_ptr_q  <= fill_ptr_d;
      drain_ptr_q <= drain_ptr_d;
      slice_cnt_q <= slice_cnt_d;
      word_cnt_q  <= word_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q[0] != BANK_EMPTY) ||
                     (state_q[1] != BANK_EMPTY) || out_valid_q;

endmodule

// File: tb/tb_ofm_packer.sv
// Directed bench for ofm_packer with a bench-side group model.
module tb_ofm_packer;
  import ofm_packer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_conv_pulse = 1'b0;
  logic [OUTPUT_WIDTH-1:0] in_data = '0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready;
  logic [INPUT_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready = 1'b0;
  logic out_last;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [COMMON_DEN-1:0] exp_bank;
  logic [INPUT_WIDTH-1:0] exp_q [$];
  logic [INPUT_WIDTH-1:0] w0;

  ofm_packer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_conv_pulse (start_conv_pulse),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_last          (in_last),
    .in_ready         (in_ready),
    .out_data         (out_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_last         (out_last),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [INPUT_WIDTH-1:0] obs,
                      input logic [INPUT_WIDTH-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [OUTPUT_WIDTH-1:0] slice_val(input int g, input int k);
    logic [7:0] kb;
    kb = 8'(k);
    if (g == 0) return OUTPUT_WIDTH'(k);
    if (g == 4) return {{9{8'hAA}}, kb};
    return {16'(g), 32'hC0DE_0000 | 32'(k), 32'(g * 1000 + k)};
  endfunction

  task automatic push_group(input int g, input int n);
    exp_bank = '0;
    for (int k = 0; k < n; k++) exp_bank[k*OUTPUT_WIDTH +: OUTPUT_WIDTH] = slice_val(g, k);
    for (int j = 0; j < REG_NUM; j++) exp_q.push_back(exp_bank[j*INPUT_WIDTH +: INPUT_WIDTH]);
  endtask

  task automatic send_group(input string tag, input int g, input int n, input logic use_last);
    for (int k = 0; k < n; k++) begin
      chk1({tag, " in_ready"}, in_ready, 1'b1);
      in_valid = 1'b1;
      in_data  = slice_val(g, k);
      in_last  = use_last && (k == n - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic recv_word(input string tag, input int maxw, input logic el);
    int w;
    logic [INPUT_WIDTH-1:0] ed;
    w = 0;
    while (!out_valid && w < maxw) begin
      step();
      w++;
    end
    ed = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk1({tag, " valid"}, out_valid, 1'b1);
    chkw({tag, " data"}, out_data, ed);
    chk1({tag, " last"}, out_last, el);
    step();
  endtask

  initial begin
    // 1: reset state
    step();
    step();
    rst_n = 1'b1;
    step();
    chk1("rst in_ready", in_ready, 1'b1);
    chk1("rst out_valid", out_valid, 1'b0);
    chkw("rst out_data", out_data, '0);
    chk1("rst out_last", out_last, 1'b0);
    chk1("rst busy", busy, 1'b0);

    // 2: one full group, slice k = k
    out_ready = 1'b1;
    send_group("t2", 0, MAX_CNT, 1'b0);
    chk1("t2 latency0", out_valid, 1'b0);
    chk1("t2 busy", busy, 1'b1);
    step();
    chk1("t2 latency1", out_valid, 1'b1);
    chki("t2 s0", int'(out_data[79:0]), 0);
    chki("t2 s1", int'(out_data[159:80]), 1);
    chki("t2 s6lo", int'(out_data[511:480]), 6);
    push_group(0, MAX_CNT);
    for (int j = 0; j < REG_NUM; j++) recv_word("t2 word", 0, 1'b0);
    chk1("t2 idle", out_valid, 1'b0);

    // 3: backpressure fills both banks, then back-to-back drain
    out_ready = 1'b0;
    send_group("t3a", 1, MAX_CNT, 1'b0);
    send_group("t3b", 2, MAX_CNT, 1'b0);
    chk1("t3 in_ready low", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = slice_val(3, 0);
    w0 = out_data;
    push_group(1, MAX_CNT);
    chkw("t3 word0", w0, exp_q[0]);
    for (int c = 0; c < 20; c++) begin
      step();
      chkw("t3 hold data", out_data, w0);
      chk1("t3 hold valid", out_valid, 1'b1);
      chk1("t3 stall", in_ready, 1'b0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    push_group(2, MAX_CNT);
    for (int j = 0; j < 2 * REG_NUM; j++) recv_word("t3 word", 0, 1'b0);
    chk1("t3 idle", out_valid, 1'b0);

    // 4: short group closed by in_last
    send_group("t4", 4, 10, 1'b1);
    push_group(4, 10);
    for (int j = 0; j < REG_NUM; j++) recv_word("t4 word", 3, j == REG_NUM - 1);
    chk1("t4 busy", busy, 1'b0);

    // 5: continuous stream of three groups
    push_group(5, MAX_CNT);
    push_group(6, MAX_CNT);
    push_group(7, MAX_CNT);
    for (int c = 0; c < 140; c++) begin
      if (c < 3 * MAX_CNT) begin
        chk1("t5 in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = slice_val(5 + c / MAX_CNT, c % MAX_CNT);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        chkw("t5 word", out_data, (exp_q.size() > 0) ? exp_q.pop_front() : '0);
        chk1("t5 last", out_last, 1'b0);
      end
      step();
    end
    chki("t5 words left", exp_q.size(), 0);

    // 6a: flush in the middle of a group
    for (int k = 0; k < 17; k++) begin
      in_valid = 1'b1;
      in_data  = slice_val(8, k);
      step();
    end
    in_data = slice_val(8, 17);
    start_conv_pulse = 1'b1;
    step();
    start_conv_pulse = 1'b0;
    in_valid = 1'b0;
    chk1("t6a out_valid", out_valid, 1'b0);
    chk1("t6a busy", busy, 1'b0);
    chk1("t6a in_ready", in_ready, 1'b1);
    send_group("t6a", 9, MAX_CNT, 1'b0);
    push_group(9, MAX_CNT);
    for (int j = 0; j < REG_NUM; j++) recv_word("t6a word", 3, 1'b0);

    // 6b: flush while word 2 is presented
    send_group("t6b", 10, MAX_CNT, 1'b0);
    push_group(10, MAX_CNT);
    recv_word("t6b word", 3, 1'b0);
    recv_word("t6b word", 0, 1'b0);
    exp_q.delete();
    chk1("t6b word2 up", out_valid, 1'b1);
    start_conv_pulse = 1'b1;
    step();
    start_conv_pulse = 1'b0;
    chk1("t6b out_valid", out_valid, 1'b0);
    chk1("t6b out_last", out_last, 1'b0);
    chk1("t6b busy", busy, 1'b0);
    step();
    chk1("t6b no resume", out_valid, 1'b0);
    send_group("t6c", 11, 6, 1'b1);
    push_group(11, 6);
    for (int j = 0; j < REG_NUM; j++) recv_word("t6c word", 3, j == REG_NUM - 1);

    // reset in mid-group drops the partial group
    send_group("t7", 12, 10, 1'b0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk1("t7 busy", busy, 1'b0);
    chk1("t7 out_valid", out_valid, 1'b0);
    chk1("t7 in_ready", in_ready, 1'b1);
    step();
    chk1("t7 still idle", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
